// File: rtl/acc_write_arbiter.sv
// Round-robin arbiter granting ALU, memory and input-port writes into the accumulator input stage.
// Optional ACC_FLAGS_EN adds registered zero/neg flags of the last written value.
module acc_write_arbiter #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reqAlu,
    input  logic [WIDTH-1:0] dataAlu,
    input  logic             reqMem,
    input  logic [WIDTH-1:0] dataMem,
    input  logic             reqIn,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             lock,
    output logic [2:0]       gnt,
    output logic [WIDTH-1:0] newData,
    output logic             accept,
    output logic [WIDTH-1:0] accValue,
`ifdef ACC_FLAGS_EN
    output logic             zero,
    output logic             neg,
`endif
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [2:0]       req;
    logic [1:0]       cand [3];
    logic             win_valid;
    logic [1:0]       win_idx;
    logic [WIDTH-1:0] win_data;

    assign req = {reqIn, reqMem, reqAlu};

    // Scan order starts at the pointer and wraps modulo 3.
    always_comb begin
        cand[0]   = ptr;
        cand[1]   = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        cand[2]   = (cand[1] == 2'd2) ? 2'd0 : cand[1] + 2'd1;
        win_valid = 1'b0;
        win_idx   = 2'd0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (!win_valid && req[cand[k]]) begin
                win_valid = 1'b1;
                win_idx   = cand[k];
            end
        end
        case (win_idx)
            2'd1:    win_data = dataMem;
            2'd2:    win_data = dataIn;
            default: win_data = dataAlu;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            gnt      <= '0;
            accept   <= 1'b0;
            busy     <= 1'b0;
            newData  <= RESET_VALUE;
            accValue <= RESET_VALUE;
`ifdef ACC_FLAGS_EN
            zero     <= (RESET_VALUE == '0);
            neg      <= RESET_VALUE[WIDTH-1];
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid && !lock) begin
                        state    <= GRANT;
                        newData  <= win_data;
                        accValue <= win_data;
`ifdef ACC_FLAGS_EN
                        zero     <= (win_data == '0);
                        neg      <= win_data[WIDTH-1];
`endif
                        gnt      <= 3'b001 << win_idx;
                        accept   <= 1'b1;
                        busy     <= 1'b1;
                        ptr      <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                    end else begin
                        gnt    <= '0;
                        accept <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    accept <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_write_arbiter.sv
// Self-checking bench for acc_write_arbiter: directed steps plus random traffic against a rule-level model.
// Define ACC_FLAGS_EN to also check the zero/neg flags.
module tb_acc_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n, reqAlu, reqMem, reqIn, lock;
    logic [7:0] dataAlu, dataMem, dataIn;
    logic [2:0] gnt;
    logic [7:0] newData, accValue;
    logic       accept, busy;
`ifdef ACC_FLAGS_EN
    logic       zero, neg;
`endif

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    bit         m_grant;
    int         m_ptr;
    logic [7:0] m_acc, m_new;
    logic [2:0] m_gnt;

    acc_write_arbiter #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqAlu(reqAlu), .dataAlu(dataAlu),
        .reqMem(reqMem), .dataMem(dataMem),
        .reqIn(reqIn), .dataIn(dataIn),
        .lock(lock), .gnt(gnt), .newData(newData), .accept(accept),
        .accValue(accValue),
`ifdef ACC_FLAGS_EN
        .zero(zero), .neg(neg),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the spec rules to the inputs present at this edge.
    task automatic model_edge();
        logic [2:0] r;
        logic [7:0] d [3];
        r = {reqIn, reqMem, reqAlu};
        d[0] = dataAlu; d[1] = dataMem; d[2] = dataIn;
        if (!rst_n) begin
            m_grant = 0; m_ptr = 0; m_acc = 8'h00; m_new = 8'h00; m_gnt = 3'b000;
        end else if (m_grant) begin
            m_grant = 0; m_gnt = 3'b000;
        end else if (!lock && r != 3'b000) begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_ptr + k) % 3;
                if (!m_grant && r[i]) begin
                    m_grant = 1;
                    m_new = d[i];
                    m_acc = d[i];
                    m_gnt = 3'(1 << i);
                    m_ptr = (i + 1) % 3;
                end
            end
        end else begin
            m_gnt = 3'b000;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
        chk({tag, ".accept"}, 32'(accept), 32'(|m_gnt));
        chk({tag, ".busy"}, 32'(busy), 32'(m_grant));
        chk({tag, ".newData"}, 32'(newData), 32'(m_new));
        chk({tag, ".accValue"}, 32'(accValue), 32'(m_acc));
`ifdef ACC_FLAGS_EN
        chk({tag, ".zero"}, 32'(zero), 32'(m_acc == 8'h00));
        chk({tag, ".neg"}, 32'(neg), 32'(m_acc[7]));
`endif
    endtask

    task automatic drive(input logic ra, input logic [7:0] da, input logic rm, input logic [7:0] dm,
                         input logic ri, input logic [7:0] di, input logic lk);
        reqAlu = ra; dataAlu = da; reqMem = rm; dataMem = dm; reqIn = ri; dataIn = di; lock = lk;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 8'hAA, 0, 8'hBB, 0, 8'hCC, 0);
        m_grant = 0; m_ptr = 0; m_acc = 8'h00; m_new = 8'h00; m_gnt = 3'b000;

        // Reset then idle
        step("rst0"); step("rst1");
        rst_n = 1'b1;
        step("idle0"); step("idle1");
        chk("idle.accValue_const", 32'(accValue), 32'h00);

        // Single memory request
        drive(0, 8'h00, 1, 8'h5A, 0, 8'h00, 0);
        step("mem.grant");
        chk("mem.gnt_const", 32'(gnt), 32'b010);
        chk("mem.newData_const", 32'(newData), 32'h5A);
        drive(0, 8'h00, 0, 8'h77, 0, 8'h00, 0);
        step("mem.release");
        chk("mem.accValue_held", 32'(accValue), 32'h5A);

        // Round-robin with all requesters; pointer now sits at In
        drive(1, 8'h01, 1, 8'h02, 1, 8'h04, 0);
        for (int c = 0; c < 8; c++) step("rr");
        drive(0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        step("rr.end"); step("rr.end");

        // Lock holds off a pending request
        drive(0, 8'h00, 0, 8'h00, 1, 8'h33, 1);
        for (int c = 0; c < 6; c++) step("lock");
        chk("lock.no_gnt", 32'(gnt), 32'b000);
        lock = 1'b0;
        step("unlock");
        chk("unlock.gnt_const", 32'(gnt), 32'b100);
        chk("unlock.newData_const", 32'(newData), 32'h33);
        reqIn = 1'b0;
        lock = 1'b1;
        step("lock_in_grant");
        lock = 1'b0;
        step("idle2");

        // Reset during GRANT
        drive(1, 8'hFF, 0, 8'h00, 0, 8'h00, 0);
        step("rg.grant");
        rst_n = 1'b0;
        step("rg.reset");
        chk("rg.accValue_const", 32'(accValue), 32'h00);
        rst_n = 1'b1;
        drive(1, 8'h11, 1, 8'h22, 0, 8'h00, 0);
        step("rg.ptr_alu");
        chk("rg.gnt_alu_const", 32'(gnt), 32'b001);
        drive(0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        step("rg.idle");

        // Flag boundary values
        drive(1, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        step("flag.zero");
        drive(0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        step("flag.gap");
        drive(0, 8'h00, 1, 8'h80, 0, 8'h00, 0);
        step("flag.neg");
        drive(0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        step("flag.gap2");

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                  1'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
